// File: rtl/dma_csr_sequencer.sv
// dma_csr_sequencer: AXI4-Lite master that programs the DMA CSRs for one linear transfer
// per job, waits for the done/error IRQ or a timeout, reads status back and returns a record.
module dma_csr_sequencer #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [31:0] DESC_CFG       = 32'h0000_0007,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [31:0]           job_src,
    input  logic [31:0]           job_dst,
    input  logic [31:0]           job_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_code,
    output logic [31:0]           rsp_status,
    output logic [31:0]           rsp_err_addr,
    output logic [31:0]           rsp_err_stats,
    output logic                  busy,
    input  logic                  dma_done_i,
    input  logic                  dma_error_i,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, WAIT_IRQ, RD_REQ, RD_RESP, RSP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [31:0] status_q, status_d, eaddr_q, eaddr_d, estats_q, estats_d;
    logic [7:0]  wr_off, rd_off;
    logic [31:0] wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            code_q    <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            status_q  <= '0;
            eaddr_q   <= '0;
            estats_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            status_q  <= status_d;
            eaddr_q   <= eaddr_d;
            estats_q  <= estats_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        status_d  = status_q;
        eaddr_d   = eaddr_q;
        estats_d  = estats_q;
        case (state_q)
            IDLE: if (job_valid) begin
                src_d    = job_src;
                dst_d    = job_dst;
                len_d    = job_len;
                idx_d    = '0;
                code_d   = 2'd0;
                status_d = '0;
                eaddr_d  = '0;
                estats_d = '0;
                state_d  = (job_len == 32'd0) ? RSP : WR_REQ;
            end
            // AW and W complete independently; the write is issued once both have landed
            WR_REQ: begin
                aw_done_d = aw_done_q | m_awready;
                w_done_d  = w_done_q | m_wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: if (m_bvalid) begin
                if (m_bresp != 2'b00) begin
                    code_d  = 2'd3;
                    state_d = RSP;
                end else if (idx_q == 3'd4) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = WAIT_IRQ;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = WR_REQ;
                end
            end
            WAIT_IRQ: begin
                cnt_d = cnt_q + 32'd1;
                if (dma_error_i) begin
                    code_d  = 2'd1;
                    state_d = RD_REQ;
                end else if (dma_done_i) begin
                    code_d  = 2'd0;
                    state_d = RD_REQ;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    code_d  = 2'd2;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: if (m_arready) state_d = RD_RESP;
            // the error-address/stats registers are only meaningful after a DMA error
            RD_RESP: if (m_rvalid) begin
                if (m_rresp != 2'b00) begin
                    code_d   = 2'd3;
                    eaddr_d  = '0;
                    estats_d = '0;
                    state_d  = RSP;
                end else begin
                    status_d = (idx_q == 3'd0) ? 32'(m_rdata) : status_q;
                    eaddr_d  = (idx_q == 3'd1) ? 32'(m_rdata) : eaddr_q;
                    estats_d = (idx_q == 3'd2) ? 32'(m_rdata) : estats_q;
                    idx_d    = idx_q + 3'd1;
                    state_d  = (code_q == 2'd1 && idx_q != 3'd2) ? RD_REQ : RSP;
                end
            end
            RSP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_off        = (idx_q == 3'd4) ? 8'h00 : {1'b0, idx_q + 3'd2, 4'h0};
        rd_off        = {3'b000, idx_q[1:0] + 2'd1, 3'b000};
        wr_data       = (idx_q == 3'd0) ? src_q :
                        (idx_q == 3'd1) ? dst_q :
                        (idx_q == 3'd2) ? len_q :
                        (idx_q == 3'd3) ? DESC_CFG : 32'h1;
        job_ready     = (state_q == IDLE);
        busy          = (state_q != IDLE);
        m_awvalid     = (state_q == WR_REQ) && !aw_done_q;
        m_wvalid      = (state_q == WR_REQ) && !w_done_q;
        m_awaddr      = (state_q == WR_REQ) ? ADDR_WIDTH'(wr_off) : '0;
        m_wdata       = (state_q == WR_REQ) ? DATA_WIDTH'(wr_data) : '0;
        m_wstrb       = 4'hF;
        m_awprot      = 3'b000;
        m_bready      = (state_q == WR_RESP);
        m_arvalid     = (state_q == RD_REQ);
        m_araddr      = (state_q == RD_REQ) ? ADDR_WIDTH'(rd_off) : '0;
        m_arprot      = 3'b000;
        m_rready      = (state_q == RD_RESP);
        rsp_valid     = (state_q == RSP);
        rsp_code      = code_q;
        rsp_status    = status_q;
        rsp_err_addr  = eaddr_q;
        rsp_err_stats = estats_q;
    end
endmodule
